// File: rtl/tlb_miss_handler_pkg.sv
// tlb_miss_handler_pkg: walker state encoding and address/PTE field geometry
package tlb_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT} ptw_state_t;
  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W = 20;
  localparam int PPN_W = 20;
  localparam int VPN_LSB = PAGE_OFFSET_W;
  localparam int PTE_PPN_MSB = 31;
  localparam int PTE_PPN_LSB = PTE_PPN_MSB - PPN_W + 1;
endpackage

// File: rtl/tlb_miss_handler_if.sv
// tlb_miss_handler_if: miss request, PTE memory read and TLB refill/fault signals
interface tlb_miss_handler_if;
  import tlb_pkg::*;
  logic flush;
  logic tlb_miss;
  logic [31:0] miss_vaddr;
  logic [31:0] ptbr;
  logic mem_req;
  logic [31:0] mem_addr;
  logic mem_ready;
  logic [31:0] mem_rdata;
  logic tlb_write;
  logic [31:0] reg_logic_page;
  logic [PPN_W-1:0] reg_physical_page;
  logic page_fault;
  logic [31:0] fault_vaddr;
  logic busy;
  modport master (
    input flush, tlb_miss, miss_vaddr, ptbr, mem_ready, mem_rdata,
    output mem_req, mem_addr, tlb_write, reg_logic_page, reg_physical_page,
    page_fault, fault_vaddr, busy
  );
  modport slave (
    output flush, tlb_miss, miss_vaddr, ptbr, mem_ready, mem_rdata,
    input mem_req, mem_addr, tlb_write, reg_logic_page, reg_physical_page,
    page_fault, fault_vaddr, busy
  );
endinterface

// File: rtl/tlb_miss_handler_ptw_timeout.sv
// ptw_timeout: WAIT-cycle counter that flags expiry after LIMIT cycles without mem_ready
module ptw_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = en && (cnt == 8'(LIMIT - 1));
  always_ff @(posedge clk) begin
    if (!reset || clear) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/tlb_miss_handler.sv
// tlb_miss_handler: single-level page-table walker refilling the TLB or raising page_fault.
// Optional WAIT timeout enabled by defining TLB_PTW_TIMEOUT_EN.
module tlb_miss_handler
  import tlb_pkg::*;
#(
  parameter int unsigned PTE_VALID_BIT = 0
`ifdef TLB_PTW_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic clk,
  input logic reset,
  tlb_miss_handler_if.master bus
);
  ptw_state_t state, state_n;
  logic [31:0] vaddr, addr, lpage, fva;
  logic [PPN_W-1:0] ppage;
  logic valid, expired;
  wire unused_pte = ^bus.mem_rdata[PTE_PPN_LSB-1:0];
  assign valid = bus.mem_rdata[PTE_VALID_BIT];
`ifdef TLB_PTW_TIMEOUT_EN
  ptw_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clear(state == REQ),
    .en(state == WAIT),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = (bus.tlb_miss && !bus.flush) ? REQ : IDLE;
      REQ: state_n = bus.flush ? IDLE : WAIT;
      WAIT: state_n = bus.flush ? IDLE : bus.mem_ready ? (valid ? FILL : FAULT) : expired ? FAULT : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // PTE address is formed at miss time so mem_addr is a stable register for the whole request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      vaddr <= '0;
      addr <= '0;
      lpage <= '0;
      ppage <= '0;
      fva <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == REQ) begin
        vaddr <= bus.miss_vaddr;
        addr <= bus.ptbr + {10'b0, bus.miss_vaddr[31:VPN_LSB], 2'b00};
      end
      if (state_n == FILL) begin
        lpage <= {{PAGE_OFFSET_W{1'b0}}, vaddr[31:VPN_LSB]};
        ppage <= bus.mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
      end
      if (state_n == FAULT) fva <= vaddr;
    end
  end
  assign bus.mem_req = (state == REQ) || (state == WAIT);
  assign bus.mem_addr = addr;
  assign bus.tlb_write = state == FILL;
  assign bus.page_fault = state == FAULT;
  assign bus.reg_logic_page = lpage;
  assign bus.reg_physical_page = ppage;
  assign bus.fault_vaddr = fva;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_tlb_miss_handler.sv
// tb_tlb_miss_handler: table-driven walks with a strobe scoreboard plus flush/reset/timeout sequences
module tb_tlb_miss_handler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  tlb_miss_handler_if bus();
  tlb_miss_handler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ptbr;
    logic [31:0] va;
    logic [31:0] rdata;
    int delay;
    logic [31:0] addr;
    logic fault;
    logic [31:0] lpage;
    logic [19:0] ppage;
  } vec_t;
  typedef struct {
    logic fault;
    logic [31:0] lpage;
    logic [19:0] ppage;
    logic [31:0] fva;
  } exp_t;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t me;
  vec_t vecs[6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (bus.tlb_write || bus.page_fault)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got tlb_write=%b page_fault=%b expected none", bus.tlb_write, bus.page_fault);
      end else begin
        me = q.pop_front();
        chk("page_fault", {31'b0, bus.page_fault}, {31'b0, me.fault});
        chk("tlb_write", {31'b0, bus.tlb_write}, {31'b0, !me.fault});
        if (me.fault) chk("fault_vaddr", bus.fault_vaddr, me.fva);
        else begin
          chk("reg_logic_page", bus.reg_logic_page, me.lpage);
          chk("reg_physical_page", {12'b0, bus.reg_physical_page}, {12'b0, me.ppage});
        end
      end
    end
  end

  task automatic start_miss(input logic [31:0] p, input logic [31:0] va);
    @(posedge clk); #1;
    bus.tlb_miss = 1'b1;
    bus.miss_vaddr = va;
    bus.ptbr = p;
    @(posedge clk); #1;
    bus.tlb_miss = 1'b0;
    bus.miss_vaddr = $urandom;
    bus.ptbr = $urandom;
  endtask

  task automatic walk(input vec_t v);
    start_miss(v.ptbr, v.va);
    chk("req_busy", {30'b0, bus.mem_req, bus.busy}, 32'd3);
    chk("mem_addr", bus.mem_addr, v.addr);
    @(posedge clk); #1;
    for (int i = 0; i < v.delay; i++) begin
      chk("wait_req_busy", {30'b0, bus.mem_req, bus.busy}, 32'd3);
      chk("wait_mem_addr", bus.mem_addr, v.addr);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = v.rdata;
    q.push_back('{v.fault, v.lpage, v.ppage, v.va});
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    chk("idle_after_walk", {29'b0, bus.busy, bus.tlb_write, bus.page_fault}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'h0001_0000, 32'h0040_3ABC, 32'h0008_7001, 1, 32'h0001_100C, 1'b0, 32'h0000_0403, 20'h00087};
    vecs[1] = '{32'h0001_0000, 32'h0040_3ABC, 32'h0008_7000, 2, 32'h0001_100C, 1'b1, 32'h0, 20'h0};
    vecs[2] = '{32'h2000_0000, 32'hABCD_E123, 32'h1234_5FFF, 10, 32'h202A_F378, 1'b0, 32'h000A_BCDE, 20'h12345};
    vecs[3] = '{32'hFFFF_FFF0, 32'h0000_5000, 32'hFFFF_F001, 3, 32'h0000_0004, 1'b0, 32'h0000_0005, 20'hFFFFF};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 32'h003F_FFFC, 1'b1, 32'h0, 20'h0};
    vecs[5] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1001, 0, 32'h0000_1004, 1'b0, 32'h0000_0001, 20'h00001};
    bus.flush = 1'b0;
    bus.tlb_miss = 1'b0;
    bus.miss_vaddr = '0;
    bus.ptbr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {28'b0, bus.mem_req, bus.tlb_write, bus.page_fault, bus.busy}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_fault_vaddr", bus.fault_vaddr, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      walk(vecs[i]);
      if (i == 1) begin
        chk("lpage_held_after_fault", bus.reg_logic_page, 32'h0000_0403);
        chk("ppage_held_after_fault", {12'b0, bus.reg_physical_page}, 32'h0000_0087);
      end
      if (i == 2) chk("fault_vaddr_held", bus.fault_vaddr, 32'h0040_3ABC);
    end
    // flush in WAIT, then a late mem_ready that must be ignored
    start_miss(32'h0001_0000, 32'h0040_3ABC);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_wait_idle", {30'b0, bus.mem_req, bus.busy}, 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0008_7001;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("late_ready_ignored", {30'b0, bus.busy, bus.tlb_write}, 32'd0);
    // flush together with mem_ready discards the PTE
    start_miss(32'h0001_0000, 32'h0040_3ABC);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.mem_ready = 1'b0;
    chk("flush_with_ready", {29'b0, bus.busy, bus.tlb_write, bus.page_fault}, 32'd0);
    // flush in REQ
    start_miss(32'h0001_0000, 32'h0040_3ABC);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_req_idle", {30'b0, bus.mem_req, bus.busy}, 32'd0);
    // flush with miss in IDLE
    bus.flush = 1'b1;
    bus.tlb_miss = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.tlb_miss = 1'b0;
    chk("flush_blocks_miss", {31'b0, bus.busy}, 32'd0);
    walk(vecs[0]);
    // reset in the middle of WAIT
    start_miss(32'h2000_0000, 32'hABCD_E123);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_ctrl", {28'b0, bus.mem_req, bus.tlb_write, bus.page_fault, bus.busy}, 32'd0);
    chk("rst_wait_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wait_lpage", bus.reg_logic_page, 32'd0);
    chk("rst_wait_ppage", {12'b0, bus.reg_physical_page}, 32'd0);
    chk("rst_wait_fault_vaddr", bus.fault_vaddr, 32'd0);
    reset = 1'b1;
    walk(vecs[3]);
    start_miss(32'h0000_0000, 32'h0BAD_0000);
`ifdef TLB_PTW_TIMEOUT_EN
    q.push_back('{1'b1, 32'h0, 20'h0, 32'h0BAD_0000});
    n = 0;
    while (!bus.page_fault && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_window", {31'b0, n >= 254 && n <= 258}, 32'd1);
    @(posedge clk); #1;
`else
    n = 0;
    repeat (300) @(posedge clk);
    #1;
    chk("wait_no_timeout", {29'b0, bus.mem_req, bus.busy, bus.page_fault}, 32'd6);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
`endif
    chk("idle_end", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
